// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C widths and responder state encoding
package i2c_pkg;

  localparam int ADDR_LEN = 7;
  localparam int DATA_LEN = 8;

  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_GET_ADDR   = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK   = 4'd2;
  localparam logic [3:0] ST_WRITE_RX   = 4'd3;
  localparam logic [3:0] ST_DATA_ACK   = 4'd4;
  localparam logic [3:0] ST_READ_TX    = 4'd5;
  localparam logic [3:0] ST_MASTER_ACK = 4'd6;
  localparam logic [3:0] ST_WAIT_STOP  = 4'd7;

endpackage

// File: rtl/i2c_slave_responder_if.sv
// rtl/i2c_slave_responder_if.sv - open-drain two-wire bus as seen by one target
interface i2c_slave_responder_if;

  logic scl;
  logic sda_in;
  logic sda_pull_low;

  modport slave (input scl, input sda_in, output sda_pull_low);
  modport master (output scl, output sda_in, input sda_pull_low);

endinterface

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - scl/sda synchronizer with edge and START/STOP detection
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_sync,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_meta;
  logic [1:0] sda_meta;
  logic       scl_hist;
  logic       sda_hist;

  // Idle bus is high, so every stage resets to 1 to avoid a phantom edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_meta <= 2'b11;
      sda_meta <= 2'b11;
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_meta <= {scl_meta[0], scl};
      sda_meta <= {sda_meta[0], sda};
      scl_hist <= scl_meta[1];
      sda_hist <= sda_meta[1];
    end
  end

  assign scl_rise  =  scl_meta[1] & ~scl_hist;
  assign scl_fall  = ~scl_meta[1] &  scl_hist;
  assign sda_sync  =  sda_meta[1];
  assign start_det = ~sda_meta[1] &  sda_hist & scl_meta[1];
  assign stop_det  =  sda_meta[1] & ~sda_hist & scl_meta[1];

endmodule

// File: rtl/i2c_slave_responder.sv
// rtl/i2c_slave_responder.sv - fixed-address I2C target with byte write/read buffers
module i2c_slave_responder #(
  parameter int                  ADDR_LEN   = i2c_pkg::ADDR_LEN,
  parameter int                  DATA_LEN   = i2c_pkg::DATA_LEN,
  parameter logic [ADDR_LEN-1:0] SLAVE_ADDR = 7'h50,
  parameter int                  NUM_BYTES  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  i2c_slave_responder_if.slave      bus,
  input  logic [DATA_LEN-1:0]       tx_data_1,
  input  logic [DATA_LEN-1:0]       tx_data_2,
  output logic [DATA_LEN-1:0]       rx_data_1,
  output logic [DATA_LEN-1:0]       rx_data_2,
  output logic                      rx_valid,
  output logic                      rx_idx,
  output logic                      busy,
  output logic [3:0]                state_slave
);

  import i2c_pkg::*;

  localparam int             BCW        = $clog2(NUM_BYTES + 1);
  localparam logic [BCW-1:0] BYTE_ONE   = BCW'(1);
  localparam logic [BCW-1:0] BYTES_FULL = BCW'(NUM_BYTES);
  localparam logic [BCW-1:0] BYTES_LAST = BCW'(NUM_BYTES - 1);
  localparam logic [3:0]     BITS_DATA  = 4'(DATA_LEN);

  logic                scl_rise;
  logic                scl_fall;
  logic                sda;
  logic                start_det;
  logic                stop_det;
  logic [3:0]          state;
  logic [3:0]          bit_cnt;
  logic [BCW-1:0]      byte_cnt;
  logic [DATA_LEN-2:0] shift;
  logic [DATA_LEN-1:0] tx_shift;
  logic [DATA_LEN-1:0] tx_next;
  logic                rw;
  logic                ack_ok;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl       (bus.scl),
    .sda       (bus.sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .sda_sync  (sda),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign busy        = (state != ST_IDLE);
  assign state_slave = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      bit_cnt          <= '0;
      byte_cnt         <= '0;
      shift            <= '0;
      tx_shift         <= '0;
      tx_next          <= '0;
      rw               <= 1'b0;
      ack_ok           <= 1'b0;
      bus.sda_pull_low <= 1'b0;
      rx_data_1        <= '0;
      rx_data_2        <= '0;
      rx_valid         <= 1'b0;
      rx_idx           <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      // Bus conditions win over any scl edge seen in the same cycle.
      if (start_det) begin
        state            <= ST_GET_ADDR;
        bit_cnt          <= '0;
        byte_cnt         <= '0;
        ack_ok           <= 1'b0;
        bus.sda_pull_low <= 1'b0;
      end else if (stop_det) begin
        state            <= ST_IDLE;
        bit_cnt          <= '0;
        byte_cnt         <= '0;
        ack_ok           <= 1'b0;
        bus.sda_pull_low <= 1'b0;
      end else begin
        case (state)
          ST_GET_ADDR: begin
            if (scl_rise && bit_cnt < BITS_DATA) begin
              shift   <= {shift[DATA_LEN-3:0], sda};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == BITS_DATA - 4'd1) begin
                rw <= sda;
                if (shift[ADDR_LEN-1:0] != SLAVE_ADDR)
                  state <= ST_WAIT_STOP;
              end
            end else if (scl_fall && bit_cnt == BITS_DATA) begin
              bus.sda_pull_low <= 1'b1;
              state            <= ST_ADDR_ACK;
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              if (!rw) begin
                bus.sda_pull_low <= 1'b0;
                bit_cnt          <= '0;
                state            <= ST_WRITE_RX;
              end else begin
                tx_shift         <= {tx_data_1[DATA_LEN-2:0], 1'b0};
                tx_next          <= tx_data_2;
                bus.sda_pull_low <= ~tx_data_1[DATA_LEN-1];
                bit_cnt          <= 4'd1;
                state            <= ST_READ_TX;
              end
            end
          end
          ST_WRITE_RX: begin
            if (scl_rise && bit_cnt < BITS_DATA) begin
              shift   <= {shift[DATA_LEN-3:0], sda};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == BITS_DATA - 4'd1 && byte_cnt != BYTES_FULL) begin
                if (byte_cnt == '0)
                  rx_data_1 <= {shift, sda};
                else
                  rx_data_2 <= {shift, sda};
                rx_valid <= 1'b1;
                rx_idx   <= byte_cnt[0];
              end
            end else if (scl_fall && bit_cnt == BITS_DATA) begin
              if (byte_cnt == BYTES_FULL) begin
                bus.sda_pull_low <= 1'b0;
                state            <= ST_WAIT_STOP;
              end else begin
                bus.sda_pull_low <= 1'b1;
                state            <= ST_DATA_ACK;
              end
            end
          end
          ST_DATA_ACK: begin
            if (scl_fall) begin
              bus.sda_pull_low <= 1'b0;
              byte_cnt         <= byte_cnt + BYTE_ONE;
              bit_cnt          <= '0;
              state            <= ST_WRITE_RX;
            end
          end
          ST_READ_TX: begin
            // tx_shift holds the bits not yet driven, MSB next.
            if (scl_fall) begin
              if (bit_cnt < BITS_DATA) begin
                bus.sda_pull_low <= ~tx_shift[DATA_LEN-1];
                tx_shift         <= {tx_shift[DATA_LEN-2:0], 1'b0};
                bit_cnt          <= bit_cnt + 4'd1;
              end else begin
                bus.sda_pull_low <= 1'b0;
                ack_ok           <= 1'b0;
                state            <= ST_MASTER_ACK;
              end
            end
          end
          ST_MASTER_ACK: begin
            if (scl_rise) begin
              if (!sda && byte_cnt < BYTES_LAST) begin
                byte_cnt <= byte_cnt + BYTE_ONE;
                ack_ok   <= 1'b1;
              end else begin
                state <= ST_WAIT_STOP;
              end
            end else if (scl_fall && ack_ok) begin
              tx_shift         <= {tx_next[DATA_LEN-2:0], 1'b0};
              bus.sda_pull_low <= ~tx_next[DATA_LEN-1];
              bit_cnt          <= 4'd1;
              ack_ok           <= 1'b0;
              state            <= ST_READ_TX;
            end
          end
          ST_WAIT_STOP: begin
            bus.sda_pull_low <= 1'b0;
          end
          ST_IDLE: begin
            bus.sda_pull_low <= 1'b0;
          end
          default: begin
            bus.sda_pull_low <= 1'b0;
            state            <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
